// File: rtl/wino_pkg.sv
// Shared Winograd PE types: 6x6 tile geometry, default element widths and drain FSM states.
package wino_pkg;
  localparam int WINO_TILE   = 6;
  localparam int WINO_DATA_W = 14;
  localparam int WINO_WGT_W  = 10;
  localparam int WINO_ACC_W  = 32;

  typedef logic [WINO_TILE-1:0][WINO_TILE-1:0][WINO_DATA_W-1:0] wino_in_tile_t;
  typedef logic [WINO_TILE-1:0][WINO_TILE-1:0][WINO_WGT_W-1:0]  wino_wgt_tile_t;
  typedef logic [WINO_TILE-1:0][WINO_TILE-1:0][WINO_ACC_W-1:0]  wino_acc_tile_t;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} wino_acc_state_e;
endpackage

// File: rtl/wino_ewmul.sv
// Stage M: registered 6x6 element-wise signed multiply with valid/addr/first pass-through.
// One-cycle latency, no backpressure: the caller gates valid.
module wino_ewmul import wino_pkg::*; #(
  parameter int DATA_W = 14,
  parameter int WGT_W  = 10,
  parameter int AW     = 4,
  localparam int PW    = DATA_W + WGT_W
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          valid,
  input  logic                                          first,
  input  logic [AW-1:0]                                 addr,
  input  logic [WINO_TILE-1:0][WINO_TILE-1:0][DATA_W-1:0] data,
  input  logic [WINO_TILE-1:0][WINO_TILE-1:0][WGT_W-1:0]  wgt,
  output logic                                          prod_valid,
  output logic                                          prod_first,
  output logic [AW-1:0]                                 prod_addr,
  output logic [WINO_TILE-1:0][WINO_TILE-1:0][PW-1:0]     prod
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_addr  <= '0;
      prod       <= '0;
    end else begin
      prod_valid <= valid;
      if (valid) begin
        prod_first <= first;
        prod_addr  <= addr;
        for (int i = 0; i < WINO_TILE; i++)
          for (int j = 0; j < WINO_TILE; j++)
            prod[i][j] <= PW'($signed(data[i][j])) * PW'($signed(wgt[i][j]));
      end
    end
  end
endmodule

// File: rtl/wino_pe_accumulator.sv
// Winograd PE lane: multiply tiles by a held weight, accumulate per block address, drain on command.
// Product +1 cycle, accumulate +2; drain is valid/ready and holds outputs while stalled. WINO_ACC_SATURATE_EN selects saturation.
module wino_pe_accumulator import wino_pkg::*; #(
  parameter int DATA_W = 14,
  parameter int WGT_W  = 10,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 16
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [WINO_TILE-1:0][WINO_TILE-1:0][DATA_W-1:0] data_i,
  input  logic [7:0]                                     addr_i,
  input  logic                                           valid_i,
  input  logic                                           first_ch_i,
  input  logic [WINO_TILE-1:0][WINO_TILE-1:0][WGT_W-1:0]  weight_i,
  input  logic                                           weight_load_i,
  input  logic                                           drain_start_i,
  input  logic [7:0]                                     block_count_i,
  output logic [WINO_TILE-1:0][WINO_TILE-1:0][ACC_W-1:0]  acc_o,
  output logic [7:0]                                     out_addr_o,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic                                           busy_o,
  output logic                                           done_o,
  output logic                                           err_o
);
  localparam int         PW      = DATA_W + WGT_W;
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  typedef logic [WINO_TILE-1:0][WINO_TILE-1:0][ACC_W-1:0] acc_tile_t;

  wino_acc_state_e                                  state;
  logic [7:0]                                       count, rd_ptr;
  logic [WINO_TILE-1:0][WINO_TILE-1:0][WGT_W-1:0]   wgt_q;
  logic                                             addr_ok, accept, drop, clamp_err, clip;
  logic                                             m_vld, m_first;
  logic [AW-1:0]                                    m_addr;
  logic [WINO_TILE-1:0][WINO_TILE-1:0][PW-1:0]      m_prod;
  acc_tile_t                                        acc_mem [DEPTH];
  acc_tile_t                                        acc_rd, acc_nxt;
  logic [ACC_W:0]                                   step;

  assign addr_ok   = {1'b0, addr_i} < DEPTH_C;
  assign accept    = valid_i && (state == IDLE) && addr_ok;
  assign drop      = valid_i && !accept;
  assign clamp_err = (state == IDLE) && drain_start_i && ({1'b0, block_count_i} > DEPTH_C);

  // A tile arriving with weight_load_i still multiplies by the previous weight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wgt_q <= '0;
    else if (weight_load_i) wgt_q <= weight_i;
  end

  wino_ewmul #(.DATA_W(DATA_W), .WGT_W(WGT_W), .AW(AW)) u_ewmul (
    .clk        (clk),
    .reset      (reset),
    .valid      (accept),
    .first      (first_ch_i),
    .addr       (addr_i[AW-1:0]),
    .data       (data_i),
    .wgt        (wgt_q),
    .prod_valid (m_vld),
    .prod_first (m_first),
    .prod_addr  (m_addr),
    .prod       (m_prod)
  );

  // Returns {clip, new_value}; a first-channel tile starts from zero instead of the entry.
  function automatic logic [ACC_W:0] acc_step(input logic signed [ACC_W-1:0] a,
                                              input logic signed [PW-1:0] p,
                                              input logic first);
`ifdef WINO_ACC_SATURATE_EN
    localparam int                SW      = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [SW-1:0] s;
    s = SW'(p);
    if (!first) s = s + SW'(a);
    if (s > SAT_MAX) return {1'b1, SAT_MAX[ACC_W-1:0]};
    if (s < SAT_MIN) return {1'b1, SAT_MIN[ACC_W-1:0]};
    return {1'b0, s[ACC_W-1:0]};
`else
    logic signed [ACC_W-1:0] s;
    s = ACC_W'(p);
    if (!first) s = s + a;
    return {1'b0, s};
`endif
  endfunction

  assign acc_rd = acc_mem[m_addr];

  always_comb begin
    acc_nxt = '0;
    clip    = 1'b0;
    step    = '0;
    for (int i = 0; i < WINO_TILE; i++)
      for (int j = 0; j < WINO_TILE; j++) begin
        step          = acc_step(acc_rd[i][j], m_prod[i][j], m_first);
        acc_nxt[i][j] = step[ACC_W-1:0];
        clip          = clip | step[ACC_W];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) acc_mem[k] <= '0;
    end else if (m_vld) begin
      acc_mem[m_addr] <= acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    err_o <= 1'b0;
    else if (drop || clamp_err || (m_vld && clip)) err_o <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rd_ptr      <= '0;
      out_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (drain_start_i) begin
          state <= FLUSH;
          count <= ({1'b0, block_count_i} > DEPTH_C) ? DEPTH_C[7:0] : block_count_i;
        end
        FLUSH: if (!m_vld) begin
          rd_ptr <= '0;
          if (count == 8'd0) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end else begin
            state       <= DRAIN;
            out_valid_o <= 1'b1;
          end
        end
        DRAIN: if (out_ready_i) begin
          if (rd_ptr == count - 8'd1) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
            rd_ptr      <= '0;
          end else begin
            rd_ptr <= rd_ptr + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_o      = out_valid_o ? acc_mem[rd_ptr[AW-1:0]] : '0;
  assign out_addr_o = rd_ptr;
  assign busy_o     = (state != IDLE) || m_vld;
endmodule
